// File: rtl/ft245_sync_device_emu_pkg.sv
// FT245 sync device emulator shared types.
// Bus strobe decode used by the top-level flag logic.
package ft245_sync_device_emu_pkg;

    typedef struct packed {
        logic rd;
        logic wr;
        logic conflict;
    } ft245_strobe_t;

    // A write with OE# asserted is a bus fight: it never qualifies as a write.
    function automatic ft245_strobe_t ft245_decode(
        input logic rdn,
        input logic wrn,
        input logic oen
    );
        ft245_strobe_t s;
        s.rd       = !rdn && !oen;
        s.wr       = !wrn && oen;
        s.conflict = !wrn && !oen;
        return s;
    endfunction

endpackage

// File: rtl/ft245_dev_fifo.sv
// Synchronous FIFO with first-word fall-through head and look-ahead count.
// Push when full and pop when empty are ignored.
module ft245_dev_fifo #(
    parameter int unsigned width = 9,
    parameter int unsigned depth = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [width-1:0]        wdata,
    output logic [width-1:0]        rdata,
    output logic [$clog2(depth):0]  count,
    output logic [$clog2(depth):0]  count_next,
    output logic                    empty,
    output logic                    full
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = aw + 1;

    logic [width-1:0] mem_q [depth];
    logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == cw'(depth));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + aw'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + aw'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + cw'(1);
                2'b01:   count_d = count_q - cw'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata      = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/ft245_sync_defs.vh
// FT245 width localparams, included inside modules that have bus_width.
localparam int unsigned ft245_dw = bus_width * 8;
localparam int unsigned ft245_bw = bus_width;
localparam int unsigned ft245_ww = ft245_dw + ft245_bw;

// File: rtl/ft245_sync_device_emu.sv
// FT245 sync FIFO device-side emulator: AXIS <-> FT245 sync bus chip end.
// Registered RXF#/TXE#/tready come from the FIFOs' look-ahead counts.
module ft245_sync_device_emu
    import ft245_sync_device_emu_pkg::*;
#(
    parameter int unsigned bus_width = 1,
    parameter int unsigned rx_depth  = 16,
    parameter int unsigned tx_depth  = 16
) (
    input  logic                     ft245_dclk,
    input  logic                     rstn,
    inout  wire  [bus_width-1:0]     ft245_ben,
    inout  wire  [bus_width*8-1:0]   ft245_data,
    input  logic                     ft245_rdn,
    input  logic                     ft245_wrn,
    input  logic                     ft245_oen,
    input  logic                     ft245_siwun,
    input  logic                     ft245_rstn,
    input  logic                     ft245_wakeupn,
    output logic                     ft245_txen,
    output logic                     ft245_rxfn,
    input  logic [bus_width*8-1:0]   s_axis_tdata,
    input  logic [bus_width-1:0]     s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [bus_width*8-1:0]   m_axis_tdata,
    output logic [bus_width-1:0]     m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     bus_err
);

    `include "ft245_sync_defs.vh"

    localparam int unsigned rx_cw = $clog2(rx_depth) + 1;
    localparam int unsigned tx_cw = $clog2(tx_depth) + 1;

    ft245_strobe_t      strb;
    logic               flush;
    logic               rx_push, rx_pop, tx_push, tx_pop;
    logic [ft245_ww-1:0] rx_head, tx_head;
    logic [rx_cw-1:0]   rx_count, rx_count_next;
    logic [tx_cw-1:0]   tx_count, tx_count_next;
    logic               rx_empty, rx_full, tx_empty, tx_full;
    logic               rd_window;

    logic rxfn_q, rxfn_d;
    logic txen_q, txen_d;
    logic tready_q, tready_d;
    logic bus_err_q, bus_err_d;

    assign strb    = ft245_decode(ft245_rdn, ft245_wrn, ft245_oen);
    assign flush   = !ft245_rstn;
    assign rx_push = s_axis_tvalid && tready_q;
    assign rx_pop  = strb.rd && !rxfn_q;
    assign tx_push = strb.wr && !txen_q;
    assign tx_pop  = m_axis_tready && !tx_empty;

    ft245_dev_fifo #(
        .width (ft245_ww),
        .depth (rx_depth)
    ) u_rx_fifo (
        .clk        (ft245_dclk),
        .rstn       (rstn),
        .flush      (flush),
        .push       (rx_push),
        .pop        (rx_pop),
        .wdata      ({s_axis_tkeep, s_axis_tdata}),
        .rdata      (rx_head),
        .count      (rx_count),
        .count_next (rx_count_next),
        .empty      (rx_empty),
        .full       (rx_full)
    );

    ft245_dev_fifo #(
        .width (ft245_ww),
        .depth (tx_depth)
    ) u_tx_fifo (
        .clk        (ft245_dclk),
        .rstn       (rstn),
        .flush      (flush),
        .push       (tx_push),
        .pop        (tx_pop),
        .wdata      ({ft245_ben, ft245_data}),
        .rdata      (tx_head),
        .count      (tx_count),
        .count_next (tx_count_next),
        .empty      (tx_empty),
        .full       (tx_full)
    );

    // Flags follow the post-edge count so they are exact the cycle after.
    always_comb begin
        rxfn_d    = (rx_count_next == '0);
        txen_d    = (tx_count_next == tx_cw'(tx_depth));
        tready_d  = (rx_count_next != rx_cw'(rx_depth));
        bus_err_d = bus_err_q || strb.conflict;
        if (flush) begin
            rxfn_d   = 1'b1;
            txen_d   = 1'b1;
            tready_d = 1'b0;
        end
    end

    always_ff @(posedge ft245_dclk) begin
        if (!rstn) begin
            rxfn_q    <= 1'b1;
            txen_q    <= 1'b1;
            tready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            rxfn_q    <= rxfn_d;
            txen_q    <= txen_d;
            tready_q  <= tready_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign rd_window  = !ft245_oen && !rx_empty;
    assign ft245_data = rd_window ? rx_head[ft245_dw-1:0] : 'z;
    assign ft245_ben  = rd_window ? rx_head[ft245_ww-1:ft245_dw] : 'z;

    assign ft245_rxfn    = rxfn_q;
    assign ft245_txen    = txen_q;
    assign s_axis_tready = tready_q;
    assign bus_err       = bus_err_q;
    assign m_axis_tvalid = !tx_empty;
    assign m_axis_tdata  = tx_head[ft245_dw-1:0];
    assign m_axis_tkeep  = tx_head[ft245_ww-1:ft245_dw];

    logic unused_ok;
    assign unused_ok = ^{ft245_siwun, ft245_wakeupn, rx_count, rx_full,
                         tx_count, tx_full};

endmodule
